// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Sequences the imem request/ack handshake, hands fetched words to decode, and applies redirects and halt.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_1,
    output logic [31:0] pc,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        halt
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] RST_S   = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DELIVER = 2'd2;
    localparam logic [1:0] HALTED  = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] instr_next;
    logic            valid_next;
    logic            accept;

    assign accept = instr_valid & instr_ready;

    // State and output registers; imem_req is decoded from the next state so it stays a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RST_S;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            instr_valid <= valid_next;
            imem_req    <= (state_next == FETCH);
        end
    end

    // Next-state decode; priority is redirect, then halt, then ack/accept.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        valid_next = instr_valid;
        case (state)
            RST_S: begin
                state_next = FETCH;
                valid_next = 1'b0;
            end
            FETCH: begin
                if (br_taken) begin
                    pc_next    = br_target;
                    valid_next = 1'b0;
                end else if (halt) begin
                    state_next = HALTED;
                    valid_next = 1'b0;
                end else if (imem_ack) begin
                    instr_next = imem_rdata;
                    valid_next = 1'b1;
                    state_next = DELIVER;
                end
            end
            DELIVER: begin
                if (br_taken) begin
                    pc_next    = br_target;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end else if (halt) begin
                    // An accept coinciding with halt still retires the instruction.
                    if (accept) begin
                        pc_next = pc_1;
                    end
                    valid_next = 1'b0;
                    state_next = HALTED;
                end else if (accept) begin
                    pc_next    = pc_1;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end
            end
            default: begin
                valid_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal checks,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RPC  = 32'h10;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_1;
    logic [31:0] pc;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        halt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: boot cycle flag, halted flag, pending-instruction flag, pc and held word.
    bit          m_boot   = 1'b1;
    bit          m_halted = 1'b0;
    bit          m_valid  = 1'b0;
    logic [31:0] m_pc     = RPC;
    logic [31:0] m_instr  = '0;

    always #5 clk = ~clk;

    // Incrementer and memory sit outside the block; memory returns a tagged copy of the address.
    assign pc_1       = pc + 32'd1;
    assign imem_rdata = pc ^ SALT;

    pc_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .pc_1(pc_1), .pc(pc),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .br_taken(br_taken), .br_target(br_target), .halt(halt)
    );

    always @(posedge clk) begin
        if (rst) begin
            m_pc = RPC; m_instr = '0; m_valid = 1'b0; m_boot = 1'b1; m_halted = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (br_taken) begin
            m_pc = br_target; m_valid = 1'b0;
        end else if (halt) begin
            if (m_valid && instr_ready) m_pc = m_pc + 32'd1;
            m_valid = 1'b0; m_halted = 1'b1;
        end else if (m_valid) begin
            if (instr_ready) begin
                m_pc = m_pc + 32'd1; m_valid = 1'b0;
            end
        end else if (imem_ack) begin
            m_instr = m_pc ^ SALT; m_valid = 1'b1;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare process: all outputs against the model on every cycle after the first reset.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_pc", pc, m_pc);
            cmp("model_req", 32'(imem_req), 32'(!m_boot && !m_halted && !m_valid));
            cmp("model_valid", 32'(instr_valid), 32'(m_valid));
            cmp("model_instr", instr, m_instr);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
        br_taken = 1'b0; br_target = '0; halt = 1'b0;
        step(); step();
        chk_en = 1'b1;
        cmp("rst_pc", pc, RPC);
        cmp("rst_req", 32'(imem_req), 32'd0);
        cmp("rst_valid", 32'(instr_valid), 32'd0);
        cmp("rst_instr", instr, 32'd0);

        // Sequential fetch at full rate.
        rst = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1;
        step(); cmp("seq_req", 32'(imem_req), 32'd1); cmp("seq_pc0", pc, 32'h10);
        step(); cmp("seq_v0", 32'(instr_valid), 32'd1); cmp("seq_i0", instr, 32'hA5A5_0010);
        step(); cmp("seq_pc1", pc, 32'h11); cmp("seq_gap", 32'(instr_valid), 32'd0);
        step(); cmp("seq_i1", instr, 32'hA5A5_0011);
        step(); cmp("seq_pc2", pc, 32'h12);

        // Memory stall, then decode stall.
        imem_ack = 1'b0; instr_ready = 1'b0;
        repeat (3) step();
        cmp("mstall_req", 32'(imem_req), 32'd1); cmp("mstall_pc", pc, 32'h12);
        imem_ack = 1'b1; step(); imem_ack = 1'b0;
        repeat (4) step();
        cmp("dstall_v", 32'(instr_valid), 32'd1); cmp("dstall_i", instr, 32'hA5A5_0012);
        cmp("dstall_pc", pc, 32'h12);
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        cmp("dstall_acc", pc, 32'h13);

        // Redirect squashing an accept, then squashing an ack in FETCH.
        imem_ack = 1'b1; step(); imem_ack = 1'b0;
        instr_ready = 1'b1; br_taken = 1'b1; br_target = 32'h200;
        step();
        cmp("br_acc_pc", pc, 32'h200); cmp("br_acc_v", 32'(instr_valid), 32'd0);
        cmp("br_acc_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1; step();
        cmp("br_ack_pc", pc, 32'h200); cmp("br_ack_v", 32'(instr_valid), 32'd0);
        br_taken = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;

        // Halt coinciding with an accept at 0x40, then ignored pulses.
        br_taken = 1'b1; br_target = 32'h40; step(); br_taken = 1'b0;
        imem_ack = 1'b1; step(); imem_ack = 1'b0;
        halt = 1'b1; instr_ready = 1'b1; step(); halt = 1'b0;
        cmp("halt_pc", pc, 32'h41); cmp("halt_req", 32'(imem_req), 32'd0);
        cmp("halt_v", 32'(instr_valid), 32'd0);
        br_taken = 1'b1; br_target = 32'h123; imem_ack = 1'b1; step();
        br_taken = 1'b0; step();
        halt = 1'b1; step(); halt = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        cmp("halt_frz_pc", pc, 32'h41); cmp("halt_frz_req", 32'(imem_req), 32'd0);
        cmp("halt_frz_v", 32'(instr_valid), 32'd0);

        // Wrap-around through the incrementer.
        rst = 1'b1; step(); rst = 1'b0; step();
        br_taken = 1'b1; br_target = 32'hFFFF_FFFF; step(); br_taken = 1'b0;
        cmp("wrap_tgt", pc, 32'hFFFF_FFFF);
        imem_ack = 1'b1; instr_ready = 1'b1;
        step(); step(); cmp("wrap_pc", pc, 32'h0);
        step(); cmp("wrap_v", 32'(instr_valid), 32'd1); cmp("wrap_i", instr, 32'hA5A5_0000);

        // Reset while an instruction is pending in DELIVER.
        instr_ready = 1'b0; imem_ack = 1'b0; rst = 1'b1; step();
        cmp("mrst_v", 32'(instr_valid), 32'd0); cmp("mrst_i", instr, 32'd0);
        cmp("mrst_pc", pc, RPC); cmp("mrst_req", 32'(imem_req), 32'd0);
        rst = 1'b0; step(); cmp("mrst_resume", 32'(imem_req), 32'd1);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            br_taken    = ($urandom_range(0, 7) == 0);
            br_target   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 4095));
            halt        = ($urandom_range(0, 39) == 0);
            imem_ack    = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; br_taken = 1'b0; halt = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the KGP RISC datapath. It holds the architectural PC, drives the PC into the `+1` incrementer, and takes the incremented value back as the sequential next-PC. It selects between sequential flow and branch/jump redirects from execute. It also sequences the instruction-memory request/acknowledge handshake and hands each fetched instruction to decode through a valid/ready handshake. The PC is word-addressed: one increment is one instruction.

## Interface
Parameters:
- `RESET_PC`, default `32'd0`: PC value loaded on reset.

Ports:
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `pc_1`, input, 32 bits: `pc + 1` returned from the incrementer; used as the sequential next-PC.
- `pc`, output, 32 bits: current PC; feeds the incrementer and instruction-memory address.
- `imem_req`, output, 1 bit: fetch request; `pc` is the address.
- `imem_ack`, input, 1 bit: instruction memory has data on `imem_rdata` this cycle.
- `imem_rdata`, input, 32 bits: fetched instruction word.
- `instr`, output, 32 bits: instruction presented to decode.
- `instr_valid`, output, 1 bit: `instr` is valid.
- `instr_ready`, input, 1 bit: decode accepts `instr` this cycle.
- `br_taken`, input, 1 bit: execute redirects the PC.
- `br_target`, input, 32 bits: redirect address.
- `halt`, input, 1 bit: decode has recognised a halt instruction.

## Operation
- States:
  - RST_S: entered on reset.
  - FETCH: `imem_req` = 1.
  - DELIVER: `instr_valid` = 1.
  - HALTED.
- Reset (`rst` = 1 at an edge), regardless of state:
  - `pc` ← `RESET_PC`, `instr` ← 0, `instr_valid` ← 0, state ← RST_S.
  - `imem_req` = 0 while in RST_S.
  - RST_S moves to FETCH unconditionally on the next edge with `rst` = 0.
- FETCH:
  - `pc` is held stable.
  - On `imem_ack` = 1: `instr` ← `imem_rdata`, `instr_valid` ← 1, state ← DELIVER.
  - With no ack, remain in FETCH indefinitely.
- DELIVER:
  - `instr` and `instr_valid` are held until accepted.
  - When `instr_valid` and `instr_ready` are both 1: `pc` ← `pc_1`, `instr_valid` ← 0, state ← FETCH.
- Redirect: `br_taken` = 1 in FETCH or DELIVER.
  - `pc` ← `br_target`, `instr_valid` ← 0, state ← FETCH.
  - Any `imem_ack` in the same cycle is discarded.
  - Any concurrent accept is squashed: `pc` takes `br_target`, not `pc_1`.
- Halt: `halt` = 1 with `br_taken` = 0, in FETCH or DELIVER.
  - state ← HALTED, `instr_valid` ← 0, `pc` frozen at its current value.
  - If `halt` coincides with an accept, `pc` still advances to `pc_1` before freezing.
- HALTED:
  - `imem_req` = 0, `instr_valid` = 0.
  - `br_taken`, `halt`, `imem_ack` and `instr_ready` are ignored.
  - Only `rst` exits this state.
- Priority: `rst` > `br_taken` > `halt` > `imem_ack` / accept.
- `imem_ack` outside FETCH is ignored.
- Arithmetic:
  - No arithmetic is performed inside the block.
  - `pc_1` and `br_target` are loaded verbatim, so `32'hFFFF_FFFF` wraps to `32'h0` via the incrementer with no flag or trap.

## Timing
- All outputs are registered or decoded from the state register only; there are no combinational input-to-output paths.
- `imem_req` is asserted in the first cycle after reset release plus one (RST_S → FETCH).
- Best-case throughput, with ack in the first FETCH cycle and ready in the first DELIVER cycle:
  - one instruction every 2 cycles.
  - `instr_valid` rises 1 cycle after the acked edge.
- Redirect latency: the new `pc` is visible the cycle after `br_taken`, with `imem_req` = 1 in that cycle.
- `pc` changes only on accept, redirect, or reset.

## Test plan
- Reset and sequential fetch:
  - Stimulus: `RESET_PC` = `32'h10`; `imem_ack` always 1; `instr_ready` always 1; memory returns `imem_rdata` = `pc` XOR `32'hA5A5_0000`.
  - Response: `pc` sequence is 10, 10, 11, 11, 12…; `instr` = `32'hA5A5_0010`, `32'hA5A5_0011`, … with one valid pulse every 2 cycles.
- Memory and decode stalls:
  - Stimulus: `imem_ack` delayed 3 cycles; then `instr_ready` held low 4 cycles.
  - Response: `imem_req` and `pc` are held for 3 cycles; then `instr` and `instr_valid` are stable for all 4 stalled cycles; `pc` increments only on the accept edge.
- Redirect with a concurrent event:
  - Stimulus: `br_taken` = 1, `br_target` = `32'h200`, in the same cycle as an accept, and separately in the same cycle as `imem_ack` in FETCH.
  - Response: next `pc` = `32'h200` with `instr_valid` = 0 in both cases; the acked data is never presented.
- Halt:
  - Stimulus: `halt` with an accept at `pc` = `32'h40`; later, `br_taken` and `imem_ack` are pulsed.
  - Response: `pc` = `32'h41` frozen; `imem_req` = 0 and `instr_valid` = 0 permanently; the later pulses have no effect until `rst`.
- Wrap-around:
  - Stimulus: `br_target` = `32'hFFFF_FFFF`, then accept with `pc_1` = 0.
  - Response: `pc` = `32'h0`, and fetch continues normally.
- Reset mid-operation:
  - Stimulus: `rst` asserted while in DELIVER with `instr_valid` = 1.
  - Response: next cycle `instr_valid` = 0, `instr` = 0, `pc` = `RESET_PC`, `imem_req` = 0; FETCH resumes 1 cycle after `rst` falls.
